// File: rtl/qmem_sram_bridge.sv
// ---------------------------------------------------------------------------
// qmem_sram_bridge
//
// Bridges a 32-bit QMEM slave port to an external asynchronous 16-bit SRAM
// (256K x 16). Each QMEM word access becomes two 16-bit SRAM accesses, low
// half first then high half, followed by a one-cycle ack. The DQ tristate
// buffer is external and keys on sram_oe_n.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   adr, cs, we, sel  : QMEM request (byte address, request, write, byte enables)
//   dat_w / dat_r     : QMEM write data / read data (dat_r valid while ack=1)
//   ack, err          : transfer-complete pulse, bus error (always 0)
//   sram_adr          : SRAM halfword address {adr[18:2], half}
//   sram_ce_n/we_n/oe_n/ub_n/lb_n : SRAM strobes, active low
//   sram_dat_w / sram_dat_r       : SRAM write data / read data
// ---------------------------------------------------------------------------
module qmem_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] adr,
    input  logic          cs,
    input  logic          we,
    input  logic [SW-1:0] sel,
    input  logic [DW-1:0] dat_w,
    output logic [DW-1:0] dat_r,
    output logic          ack,
    output logic          err,
    output logic [17:0]   sram_adr,
    output logic          sram_ce_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n,
    output logic          sram_oe_n,
    output logic [15:0]   sram_dat_w,
    input  logic [15:0]   sram_dat_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Request latched on acceptance.
    logic [16:0]   wadr_q;
    logic          we_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] wdat_q;

    // Next values of the registered outputs.
    logic [17:0]   sram_adr_d;
    logic          sram_ce_n_d, sram_we_n_d, sram_oe_n_d;
    logic          sram_ub_n_d, sram_lb_n_d;
    logic [15:0]   sram_dat_w_d;
    logic [DW-1:0] dat_r_d;
    logic          ack_d;

    logic          accept;

    // Handshake: a request is taken on a rising edge where the FSM is IDLE
    // and cs=1; adr/we/sel/dat_w are captured on that edge and may change
    // afterwards. The transfer always runs to completion (cs may drop) and
    // ack is high for exactly one cycle, 3 clocks after the accepting edge.
    // All outputs are registered off the FSM state, so they trail it by one
    // clock: the pins show the LO half while the FSM is in HI, the HI half
    // while it is in DONE, and ack rises as the FSM returns to IDLE. Hence a
    // cs held high is accepted on the edge that ends the ack cycle, giving
    // 4 clocks per word with no overlap of SRAM strobes.
    assign accept = (state_q == IDLE) && cs;

    // Bits outside the halfword-pair index carry no meaning for this SRAM.
    logic unused_adr;
    assign unused_adr = ^{adr[AW-1:19], adr[1:0]};

    assign err = 1'b0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wadr_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            wadr_q <= adr[18:2];
            we_q   <= we;
            sel_q  <= sel;
            wdat_q <= dat_w;
        end
    end

    // Output logic: next value of every registered output
    always_comb begin
        sram_ce_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_ub_n_d  = 1'b1;
        sram_lb_n_d  = 1'b1;
        sram_adr_d   = sram_adr;
        sram_dat_w_d = sram_dat_w;
        dat_r_d      = dat_r;
        ack_d        = (state_q == DONE);

        case (state_q)
            LO: begin
                sram_ce_n_d = 1'b0;
                sram_we_n_d = ~we_q;
                sram_oe_n_d = we_q;
                sram_lb_n_d = ~sel_q[0];
                sram_ub_n_d = ~sel_q[1];
                sram_adr_d  = {wadr_q, 1'b0};
                if (we_q) sram_dat_w_d = wdat_q[15:0];
            end
            HI: begin
                sram_ce_n_d = 1'b0;
                sram_we_n_d = ~we_q;
                sram_oe_n_d = we_q;
                sram_lb_n_d = ~sel_q[2];
                sram_ub_n_d = ~sel_q[3];
                sram_adr_d  = {wadr_q, 1'b1};
                if (we_q) sram_dat_w_d = wdat_q[31:16];
            end
            default: ;
        endcase

        // The pins trail the state by a clock, so while in HI the SRAM is
        // driving the low half and while in DONE it is driving the high half.
        // Unselected byte lanes read back as zero.
        if (!we_q) begin
            if (state_q == HI) begin
                dat_r_d[15:8]  = sel_q[1] ? sram_dat_r[15:8] : 8'h00;
                dat_r_d[7:0]   = sel_q[0] ? sram_dat_r[7:0]  : 8'h00;
            end else if (state_q == DONE) begin
                dat_r_d[31:24] = sel_q[3] ? sram_dat_r[15:8] : 8'h00;
                dat_r_d[23:16] = sel_q[2] ? sram_dat_r[7:0]  : 8'h00;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_adr   <= '0;
            sram_dat_w <= '0;
            dat_r      <= '0;
            ack        <= 1'b0;
        end else begin
            sram_ce_n  <= sram_ce_n_d;
            sram_we_n  <= sram_we_n_d;
            sram_oe_n  <= sram_oe_n_d;
            sram_ub_n  <= sram_ub_n_d;
            sram_lb_n  <= sram_lb_n_d;
            sram_adr   <= sram_adr_d;
            sram_dat_w <= sram_dat_w_d;
            dat_r      <= dat_r_d;
            ack        <= ack_d;
        end
    end

endmodule

// File: tb/tb_qmem_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_qmem_sram_bridge
//
// Directed bench for qmem_sram_bridge with a behavioural 16-bit SRAM model.
// Each QMEM transfer is checked cycle by cycle: idle pins on the accepting
// edge, LO half pins, HI half pins, then the ack cycle with read data.
// ---------------------------------------------------------------------------
module tb_qmem_sram_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic        cs;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic [17:0] sram_adr;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_oe_n;
    logic [15:0] sram_dat_w;
    logic [15:0] sram_dat_r;

    int n_checks = 0;
    int n_errors = 0;

    logic        mem_clr;
    logic [15:0] mem [0:255];

    qmem_sram_bridge #(.AW(32), .DW(32), .SW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .adr        (adr),
        .cs         (cs),
        .we         (we),
        .sel        (sel),
        .dat_w      (dat_w),
        .dat_r      (dat_r),
        .ack        (ack),
        .err        (err),
        .sram_adr   (sram_adr),
        .sram_ce_n  (sram_ce_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n),
        .sram_oe_n  (sram_oe_n),
        .sram_dat_w (sram_dat_w),
        .sram_dat_r (sram_dat_r)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    // A write lands at the end of the cycle in which the strobes are held,
    // so a strobe cut short by reset writes nothing.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_adr[7:0]][7:0]  <= sram_dat_w[7:0];
            if (!sram_ub_n) mem[sram_adr[7:0]][15:8] <= sram_dat_w[15:8];
        end
    end

    // Disabled lanes drive a junk pattern so that masking is visible.
    always_comb begin
        sram_dat_r = 16'hA5A5;
        if (!sram_ce_n && !sram_oe_n) begin
            sram_dat_r[7:0]  = sram_lb_n ? 8'hA5 : mem[sram_adr[7:0]][7:0];
            sram_dat_r[15:8] = sram_ub_n ? 8'hA5 : mem[sram_adr[7:0]][15:8];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {27'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n};
    endfunction

    // One QMEM transfer. exp_rd is the dat_r value required in the ack
    // cycle (the read result, or the previous value for a write). With
    // hold=1, cs stays high after the accepting edge.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic hold);
        @(negedge clk);
        cs    = 1'b1;
        we    = w;
        adr   = a;
        sel   = s;
        dat_w = wd;
        @(posedge clk); #1;
        if (!hold) cs = 1'b0;
        check({tag, ".e0_ack"},     {31'd0, ack}, 32'd0);
        check({tag, ".e0_strobes"}, strobes(),    32'h1f);
        @(posedge clk); #1;
        check({tag, ".lo_ack"},     {31'd0, ack}, 32'd0);
        check({tag, ".lo_strobes"}, strobes(),    {27'd0, 1'b0, ~w, w, ~s[1], ~s[0]});
        check({tag, ".lo_adr"},     {14'd0, sram_adr}, {14'd0, a[18:2], 1'b0});
        if (w) check({tag, ".lo_dat_w"}, {16'd0, sram_dat_w}, {16'd0, wd[15:0]});
        @(posedge clk); #1;
        check({tag, ".hi_ack"},     {31'd0, ack}, 32'd0);
        check({tag, ".hi_strobes"}, strobes(),    {27'd0, 1'b0, ~w, w, ~s[3], ~s[2]});
        check({tag, ".hi_adr"},     {14'd0, sram_adr}, {14'd0, a[18:2], 1'b1});
        if (w) check({tag, ".hi_dat_w"}, {16'd0, sram_dat_w}, {16'd0, wd[31:16]});
        @(posedge clk); #1;
        check({tag, ".ack"},         {31'd0, ack}, 32'd1);
        check({tag, ".ack_strobes"}, strobes(),    32'h1f);
        check({tag, ".ack_err"},     {31'd0, err}, 32'd0);
        check({tag, ".dat_r"},       dat_r,        exp_rd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst     = 1'b1;
        mem_clr = 1'b1;
        cs      = 1'b0;
        we      = 1'b0;
        adr     = 32'h0;
        sel     = 4'h0;
        dat_w   = 32'h0;

        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        check("rst.strobes",  strobes(),             32'h1f);
        check("rst.ack",      {31'd0, ack},          32'd0);
        check("rst.err",      {31'd0, err},          32'd0);
        check("rst.dat_r",    dat_r,                 32'h0);
        check("rst.adr",      {14'd0, sram_adr},     32'h0);
        check("rst.dat_w",    {16'd0, sram_dat_w},   32'h0);
        rst = 1'b0;

        // Zero word round trip
        xfer("w0",  1'b1, 32'h0000_0000, 4'hf, 32'h0000_0000, 32'h0000_0000, 1'b0);
        xfer("r0",  1'b0, 32'h0000_0000, 4'hf, 32'h0,         32'h0000_0000, 1'b0);

        // Consecutive words
        xfer("w10", 1'b1, 32'h0000_0010, 4'hf, 32'h0001_0001, 32'h0000_0000, 1'b0);
        xfer("w14", 1'b1, 32'h0000_0014, 4'hf, 32'h0001_0002, 32'h0000_0000, 1'b0);
        xfer("w18", 1'b1, 32'h0000_0018, 4'hf, 32'h0001_0003, 32'h0000_0000, 1'b0);
        xfer("w1c", 1'b1, 32'h0000_001c, 4'hf, 32'h0001_0004, 32'h0000_0000, 1'b0);
        check("mem8",  {16'd0, mem[8]},  32'h0001);
        check("mem9",  {16'd0, mem[9]},  32'h0001);
        check("mem15", {16'd0, mem[15]}, 32'h0001);
        xfer("r10", 1'b0, 32'h0000_0010, 4'hf, 32'h0, 32'h0001_0001, 1'b0);
        xfer("r14", 1'b0, 32'h0000_0014, 4'hf, 32'h0, 32'h0001_0002, 1'b0);
        xfer("r18", 1'b0, 32'h0000_0018, 4'hf, 32'h0, 32'h0001_0003, 1'b0);
        xfer("r1c", 1'b0, 32'h0000_001c, 4'hf, 32'h0, 32'h0001_0004, 1'b0);

        // Half ordering
        xfer("wdead", 1'b1, 32'h0000_0000, 4'hf, 32'hdead_beef, 32'h0001_0004, 1'b0);
        check("mem0", {16'd0, mem[0]}, 32'hbeef);
        check("mem1", {16'd0, mem[1]}, 32'hdead);
        xfer("rdead", 1'b0, 32'h0000_0000, 4'hf, 32'h0, 32'hdead_beef, 1'b0);

        // Partial byte enables
        xfer("wff",   1'b1, 32'h0000_0004, 4'hf, 32'hffff_ffff, 32'hdead_beef, 1'b0);
        xfer("wpart", 1'b1, 32'h0000_0004, 4'h3, 32'h1234_5678, 32'hdead_beef, 1'b0);
        check("mem2", {16'd0, mem[2]}, 32'h5678);
        check("mem3", {16'd0, mem[3]}, 32'hffff);
        xfer("rpart", 1'b0, 32'h0000_0004, 4'h3, 32'h0, 32'h0000_5678, 1'b0);
        xfer("rhi",   1'b0, 32'h0000_0000, 4'hc, 32'h0, 32'hdead_0000, 1'b0);
        xfer("rmid",  1'b0, 32'h0000_0000, 4'h6, 32'h0, 32'h00ad_be00, 1'b0);

        // Writes leave dat_r alone
        xfer("whold", 1'b1, 32'h0000_0020, 4'hf, 32'h0bad_f00d, 32'h00ad_be00, 1'b0);

        // Read then write with cs held high across the boundary
        xfer("b2b_r", 1'b0, 32'h0000_0010, 4'hf, 32'h0,         32'h0001_0001, 1'b1);
        xfer("b2b_w", 1'b1, 32'h0000_0010, 4'hf, 32'hcafe_f00d, 32'h0001_0001, 1'b0);

        // Ignored address bits
        xfer("ralias", 1'b0, 32'h8000_0013, 4'hf, 32'h0, 32'hcafe_f00d, 1'b0);

        // Reset during the HI half of a write
        @(negedge clk);
        cs    = 1'b1;
        we    = 1'b1;
        adr   = 32'h0000_0040;
        sel   = 4'hf;
        dat_w = 32'h1111_2222;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("rhi.in_hi", strobes(), 32'h04);
        #2;
        rst = 1'b1;
        #1;
        check("rhi.strobes", strobes(),         32'h1f);
        check("rhi.ack",     {31'd0, ack},      32'd0);
        check("rhi.dat_r",   dat_r,             32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rhi.after1_ack",     {31'd0, ack}, 32'd0);
        check("rhi.after1_strobes", strobes(),    32'h1f);
        @(posedge clk); #1;
        check("rhi.after2_ack",     {31'd0, ack}, 32'd0);
        check("rhi.after2_strobes", strobes(),    32'h1f);
        check("mem32", {16'd0, mem[32]}, 32'h2222);
        check("mem33", {16'd0, mem[33]}, 32'h0000);
        xfer("r40", 1'b0, 32'h0000_0040, 4'hf, 32'h0, 32'h0000_2222, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
